evq_heap_ctrl: RTL
==================

# evq_heap_ctrl

Initiator-side controller for the pipelined priority heap holding pending simulation events. Accepts event-insert requests and lowest-timestamp pop requests from the scheduler over two independent valid/ready channels. Arbitrates between them, drives the heap's enq/deq/data port within the heap's issue-rate and full/empty rules, and returns popped events through a registered response channel.

## Interface
- WIDTH, 16, event word width, equal to the heap data width
- CNT_W, 5, heap element-count width; heap capacity = 2^CNT_W − 1
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low; clock clk
- ins_valid  in  1  insert request
- ins_ready  out  1  insert accepted when ins_valid & ins_ready
- ins_data  in  WIDTH  event to insert; the heap orders events on the full word
- pop_valid  in  1  pop request
- pop_ready  out  1  pop accepted when pop_valid & pop_ready
- rsp_valid  out  1  popped event available
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_data  out  WIDTH  popped event
- h_enq  out  1  heap enqueue strobe
- h_deq  out  1  heap dequeue strobe
- h_data  out  WIDTH  heap input data
- h_out  in  WIDTH  heap head (minimum)
- h_cnt  in  CNT_W  heap element count
- h_full  in  1  heap full
- h_empty  in  1  heap empty
- h_ready  in  1  heap ready; low during the enq cycle and the cycle after it

## Operation
- States are IDLE and COOL. Any heap operation moves the FSM IDLE→COOL. COOL always returns to IDLE on the next cycle. The heap therefore sees at most one operation every 2 cycles.
- An insert is eligible when all of these hold: state==IDLE, h_ready, !h_full.
- A pop is eligible when all of these hold: state==IDLE, h_ready, !h_empty, and (!rsp_valid | rsp_ready).
- Arbitration:
  - If both requests are valid and both are eligible, the grant alternates.
  - A last_grant flag records the most recent winner; the other requester wins next.
  - Reset value of last_grant is POP, so the insert wins the first tie.
- ins_ready and pop_ready are combinational and include the grant. They never depend on ins_valid or pop_valid of their own channel.
- Heap strobes are combinational from the handshakes:
  - h_enq = ins_valid & ins_ready
  - h_deq = pop_valid & pop_ready
  - h_data = ins_data
  - h_enq and h_deq are never high together. The heap does not support a combined enq+deq.
- Pop response:
  - On h_deq, rsp_data <= h_out and rsp_valid <= 1.
  - rsp_valid clears on a response handshake unless a new pop fires in the same cycle.
  - rsp_data holds stable while rsp_valid & !rsp_ready.
- h_cnt is used only for statistics. Flow control uses h_full and h_empty. The COOL cycle guarantees both are current when next sampled.
- Reset values: state IDLE, rsp_valid 0, rsp_data 0, last_grant POP.
  - ins_ready and pop_ready are 0 during reset and in COOL.
  - h_enq and h_deq are 0 during reset.
- Reset asserted mid-operation: the FSM returns to IDLE and any held response is discarded. The heap is reset from the same rst_n.

## Timing
- Insert accepted at edge t: h_enq is high in cycle t. The next accept of either type is possible no earlier than cycle t+2.
- Pop accepted in cycle t: rsp_valid is high from cycle t+1, with rsp_data equal to the h_out value in cycle t.
- Back-to-back pops with rsp_ready held high: one response every 2 cycles.
- Pop from an empty heap is never issued; pop_ready stays 0. Insert into a full heap is never issued; ins_ready stays 0.
- An insert that makes the heap full blocks further inserts. h_full is valid by the IDLE cycle after COOL.
- A pending response blocks new pops until it is consumed, unless it is consumed in the same cycle as the new pop.

## Configuration
- EVQ_STATS_EN defined adds three outputs:
  - stat_enq [31:0], total inserts
  - stat_deq [31:0], total pops
  - stat_peak [CNT_W-1:0], maximum h_cnt seen
- Statistics details:
  - All three reset to 0.
  - The counters saturate at all-ones.
  - stat_peak updates every cycle that h_cnt > stat_peak.
- EVQ_STATS_EN undefined: these ports and registers are absent. Core behaviour is identical either way.

## Structure
- Shared package evq_pkg holds:
  - the FSM state enum (EVQ_IDLE, EVQ_COOL)
  - the grant encoding (GNT_INS, GNT_POP)
  - the heap op constants (OP_NOP=0, OP_ENQ=1, OP_DEQ=2, OP_ENQ_DEQ=3) shared with the heap
- One sub-module, evq_rr_arb: a 2-requester round-robin arbiter with the last_grant register.
- Everything else is flat in evq_heap_ctrl.

## Test plan
- Insert 5,3,9 with no pops:
  - h_enq pulses at most once per 2 cycles
  - h_data matches each inserted value
  - ins_ready is 0 during each COOL cycle
- Insert 5,3,9, then pop three times with rsp_ready=1 → responses 3,5,9, each with rsp_valid one cycle after its h_deq.
- ins_valid and pop_valid both held high, heap non-empty and non-full, starting after reset → grants alternate INS, POP, INS, POP; h_enq and h_deq never high together.
- Fill the heap to 31 entries → ins_ready stays 0 while ins_valid=1. Pop one → the next insert is accepted.
- Empty heap, pop_valid=1 → pop_ready is 0 and h_deq is never asserted. Insert 7 → the pop is accepted and rsp_data=7.
- Pop with rsp_ready=0 → rsp_data holds and a second pop is blocked. Assert rst_n=0 mid-hold → rsp_valid=0 and state IDLE on the next cycle.

Source files
------------

// File: rtl/evq_pkg.sv
// Shared definitions for the event-queue heap controller and the heap itself:
// FSM states, arbiter grant encoding and the heap operation codes.
package evq_pkg;

    typedef enum logic {
        EVQ_IDLE = 1'b0,
        EVQ_COOL = 1'b1
    } evq_state_e;

    typedef enum logic {
        GNT_INS = 1'b0,
        GNT_POP = 1'b1
    } evq_gnt_e;

    localparam logic [1:0] OP_NOP     = 2'd0;
    localparam logic [1:0] OP_ENQ     = 2'd1;
    localparam logic [1:0] OP_DEQ     = 2'd2;
    localparam logic [1:0] OP_ENQ_DEQ = 2'd3;

    function automatic logic [1:0] heap_op(input logic enq, input logic deq);
        return {deq, enq};
    endfunction

endpackage

// File: rtl/evq_heap_ctrl_if.sv
// Bundle of the scheduler insert/pop/response channels and the heap port.
// slave = the controller, master = scheduler plus heap (the environment).
interface evq_heap_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
);
    logic             ins_valid;
    logic             ins_ready;
    logic [WIDTH-1:0] ins_data;
    logic             pop_valid;
    logic             pop_ready;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             h_enq;
    logic             h_deq;
    logic [WIDTH-1:0] h_data;
    logic [WIDTH-1:0] h_out;
    logic [CNT_W-1:0] h_cnt;
    logic             h_full;
    logic             h_empty;
    logic             h_ready;

    modport master (
        output ins_valid, ins_data, pop_valid, rsp_ready,
        output h_out, h_cnt, h_full, h_empty, h_ready,
        input  ins_ready, pop_ready, rsp_valid, rsp_data,
        input  h_enq, h_deq, h_data
    );

    modport slave (
        input  ins_valid, ins_data, pop_valid, rsp_ready,
        input  h_out, h_cnt, h_full, h_empty, h_ready,
        output ins_ready, pop_ready, rsp_valid, rsp_data,
        output h_enq, h_deq, h_data
    );
endinterface

// File: rtl/evq_rr_arb.sv
// Two-requester round-robin arbiter (insert vs pop). A grant never depends on
// its own requester's valid, so ready signals stay free of valid->ready paths.
module evq_rr_arb
    import evq_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_req_ins,
    input  logic i_req_pop,
    input  logic i_elig_ins,
    input  logic i_elig_pop,
    input  logic i_fire_ins,
    input  logic i_fire_pop,
    output logic o_gnt_ins,
    output logic o_gnt_pop
);
    evq_gnt_e r_last_grant;

    // Yield only when the other side is actually contending and won less recently.
    assign o_gnt_ins = i_elig_ins & ~(i_req_pop & i_elig_pop & (r_last_grant == GNT_INS));
    assign o_gnt_pop = i_elig_pop & ~(i_req_ins & i_elig_ins & (r_last_grant == GNT_POP));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_grant <= GNT_POP;
        end else if (i_fire_ins) begin
            r_last_grant <= GNT_INS;
        end else if (i_fire_pop) begin
            r_last_grant <= GNT_POP;
        end
    end
endmodule

// File: rtl/evq_heap_ctrl.sv
// Scheduler-side controller for the pipelined event heap: arbitrates inserts and
// pops, paces heap ops to one per 2 cycles, registers popped events. Optional stats: EVQ_STATS_EN.
module evq_heap_ctrl
    import evq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    evq_heap_ctrl_if.slave    bus
`ifdef EVQ_STATS_EN
    ,
    output logic [31:0]       stat_enq,
    output logic [31:0]       stat_deq,
    output logic [CNT_W-1:0]  stat_peak
`endif
);
    evq_state_e       r_state;
    evq_state_e       w_state_next;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_data;
    logic             w_idle;
    logic             w_elig_ins;
    logic             w_elig_pop;
    logic             w_gnt_ins;
    logic             w_gnt_pop;
    logic [1:0]       w_op;

    // rst_n gates eligibility so nothing handshakes while reset is held.
    assign w_idle     = rst_n & (r_state == EVQ_IDLE) & bus.h_ready;
    assign w_elig_ins = w_idle & ~bus.h_full;
    assign w_elig_pop = w_idle & ~bus.h_empty & (~r_rsp_valid | bus.rsp_ready);
    assign w_op       = heap_op(bus.h_enq, bus.h_deq);

    evq_rr_arb u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req_ins  (bus.ins_valid),
        .i_req_pop  (bus.pop_valid),
        .i_elig_ins (w_elig_ins),
        .i_elig_pop (w_elig_pop),
        .i_fire_ins (bus.h_enq),
        .i_fire_pop (bus.h_deq),
        .o_gnt_ins  (w_gnt_ins),
        .o_gnt_pop  (w_gnt_pop)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= EVQ_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = EVQ_IDLE;
        case (r_state)
            EVQ_IDLE: begin
                case (w_op)
                    OP_ENQ, OP_DEQ, OP_ENQ_DEQ: w_state_next = EVQ_COOL;
                    default:                    w_state_next = EVQ_IDLE;
                endcase
            end
            EVQ_COOL: w_state_next = EVQ_IDLE;
            default:  w_state_next = EVQ_IDLE;
        endcase
    end

    always_comb begin
        bus.ins_ready = w_gnt_ins;
        bus.pop_ready = w_gnt_pop;
        bus.h_enq     = bus.ins_valid & w_gnt_ins;
        bus.h_deq     = bus.pop_valid & w_gnt_pop;
        bus.h_data    = bus.ins_data;
        bus.rsp_valid = r_rsp_valid;
        bus.rsp_data  = r_rsp_data;
    end

    // A new pop in the same cycle as a consume overrides the clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else if (bus.h_deq) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= bus.h_out;
        end else if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

`ifdef EVQ_STATS_EN
    logic [31:0]      r_stat_enq;
    logic [31:0]      r_stat_deq;
    logic [CNT_W-1:0] r_stat_peak;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_enq  <= '0;
            r_stat_deq  <= '0;
            r_stat_peak <= '0;
        end else begin
            if (bus.h_enq && (r_stat_enq != '1)) begin
                r_stat_enq <= r_stat_enq + 32'd1;
            end
            if (bus.h_deq && (r_stat_deq != '1)) begin
                r_stat_deq <= r_stat_deq + 32'd1;
            end
            if (bus.h_cnt > r_stat_peak) begin
                r_stat_peak <= bus.h_cnt;
            end
        end
    end

    assign stat_enq  = r_stat_enq;
    assign stat_deq  = r_stat_deq;
    assign stat_peak = r_stat_peak;
`else
    // Element count only feeds statistics; terminate it when they are built out.
    logic [CNT_W-1:0] w_unused_cnt;
    assign w_unused_cnt = bus.h_cnt;
`endif

endmodule
